parking_gate_sequencer: RTL

Event initiator for the parking slot bookkeeping. It takes raw entrance and exit requests from the gate sensors, allocates a free slot for each entering car, and validates the slot of each leaving car against the live occupancy vector. It drives the gate barriers, then issues exactly one registered update event per completed passage: slot index plus direction. It sits between the gate sensor/actuator pads and the slot manager, and consumes the slot manager's `slot_status` as feedback.

---
 rtl/parking_gate_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/parking_gate_sequencer.sv
// ---------------------------------------------------------------------------
// parking_gate_sequencer
//
// Sequences one car passage at a time through either the entrance or the
// exit barrier. The block allocates the lowest free slot for an entering
// car, checks the claimed slot of a leaving car against the live occupancy
// vector, holds the matching barrier open until the car has passed or the
// wait times out, and issues exactly one occupancy update per passage.
//
// Ports:
//   clk             clock
//   reset           asynchronous, active-high reset
//   entry_req       car waiting at the entrance (level)
//   exit_req        car waiting at the exit (level)
//   exit_slot       slot index the exiting car claims
//   car_passed      barrier sensor pulse: car cleared the open gate
//   slot_status     occupancy vector from the slot manager (1 = occupied)
//   entry_gate_open entrance barrier drive
//   exit_gate_open  exit barrier drive
//   update_valid    one-cycle occupancy event strobe
//   update_slot     slot index of the event
//   update_entry    1 = slot becomes occupied, 0 = slot becomes free
//   assigned_slot   slot allocated to the most recent entering car
//   full            combinational: every slot occupied
//   busy            a passage is in progress
//   reject          one-cycle pulse: request refused
//   timeout         one-cycle pulse: gate closed without a passage
// ---------------------------------------------------------------------------
module parking_gate_sequencer #(
    parameter int NUM_SLOTS      = 4,
    parameter int SLOT_W         = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 entry_req,
    input  logic                 exit_req,
    input  logic [SLOT_W-1:0]    exit_slot,
    input  logic                 car_passed,
    input  logic [NUM_SLOTS-1:0] slot_status,
    output logic                 entry_gate_open,
    output logic                 exit_gate_open,
    output logic                 update_valid,
    output logic [SLOT_W-1:0]    update_slot,
    output logic                 update_entry,
    output logic [SLOT_W-1:0]    assigned_slot,
    output logic                 full,
    output logic                 busy,
    output logic                 reject,
    output logic                 timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_GATE,
        EXIT_GATE,
        UPDATE,
        SETTLE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [SLOT_W-1:0]   slot_q;
    logic [SLOT_W-1:0]   slot_next;
    logic [SLOT_W-1:0]   free_slot;
    logic [SLOT_W-1:0]   assigned_next;
    logic [SLOT_W-1:0]   update_slot_next;
    logic                update_entry_next;
    logic                reject_next;
    logic                timeout_next;

    assign full = &slot_status;

    // Lowest-index free slot. Scanning from the top down lets the lowest
    // zero bit overwrite any higher one.
    always_comb begin
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_status[i]) begin
                free_slot = SLOT_W'(i);
            end
        end
    end

    // Next-state and next-output logic. Exit requests take priority over
    // entry requests because a departure frees capacity. In a gate state a
    // car_passed on the terminal count still wins over the timeout.
    always_comb begin
        state_next        = state;
        cnt_next          = cnt;
        slot_next         = slot_q;
        assigned_next     = assigned_slot;
        update_slot_next  = update_slot;
        update_entry_next = update_entry;
        reject_next       = 1'b0;
        timeout_next      = 1'b0;

        case (state)
            IDLE: begin
                if (exit_req) begin
                    if (slot_status[exit_slot]) begin
                        slot_next  = exit_slot;
                        cnt_next   = '0;
                        state_next = EXIT_GATE;
                    end else begin
                        reject_next = 1'b1;
                    end
                end else if (entry_req) begin
                    if (!full) begin
                        slot_next     = free_slot;
                        assigned_next = free_slot;
                        cnt_next      = '0;
                        state_next    = ENTRY_GATE;
                    end else begin
                        reject_next = 1'b1;
                    end
                end
            end

            ENTRY_GATE, EXIT_GATE: begin
                if (car_passed) begin
                    update_slot_next  = slot_q;
                    update_entry_next = (state == ENTRY_GATE);
                    state_next        = UPDATE;
                end else if (cnt == CNT_LAST) begin
                    timeout_next = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            UPDATE: begin
                state_next = SETTLE;
            end

            SETTLE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers. Outputs are derived from the next state so
    // that a gate opens on the same edge that samples the request and closes
    // on the same edge that samples car_passed or the terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            slot_q          <= '0;
            assigned_slot   <= '0;
            update_slot     <= '0;
            update_entry    <= 1'b0;
            update_valid    <= 1'b0;
            entry_gate_open <= 1'b0;
            exit_gate_open  <= 1'b0;
            busy            <= 1'b0;
            reject          <= 1'b0;
            timeout         <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_next;
            slot_q          <= slot_next;
            assigned_slot   <= assigned_next;
            update_slot     <= update_slot_next;
            update_entry    <= update_entry_next;
            update_valid    <= (state_next == UPDATE);
            entry_gate_open <= (state_next == ENTRY_GATE);
            exit_gate_open  <= (state_next == EXIT_GATE);
            busy            <= (state_next != IDLE);
            reject          <= reject_next;
            timeout         <= timeout_next;
        end
    end

endmodule
